// File: rtl/fetch_aligner_if.sv
// Handshake bundle between the fetch unit, the halfword aligner and the
// downstream RVC expander/decoder.
interface fetch_aligner_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic        instr_is_rvc;
    logic [31:0] instr_pc;

    modport master (
        output fetch_valid, fetch_data, flush, flush_pc, instr_ready,
        input  fetch_ready, instr_valid, instr_data, instr_is_rvc, instr_pc
    );

    modport slave (
        input  fetch_valid, fetch_data, flush, flush_pc, instr_ready,
        output fetch_ready, instr_valid, instr_data, instr_is_rvc, instr_pc
    );
endinterface

// File: rtl/fetch_aligner.sv
// Splits word-aligned fetch words into whole 16/32-bit instructions through a
// 4-entry halfword FIFO. Compressed support is enabled by FETCH_ALIGNER_RVC_EN.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    fetch_aligner_if.slave bus
);

    logic [15:0] buf_q [4];
    logic [15:0] buf_d [4];
    logic [2:0]  count_q, count_d;
    logic [31:0] pc_q, pc_d;
    logic        skip_q, skip_d;

    logic        head_rvc;
    logic        push, pop;
    logic [2:0]  pop_cnt;
    logic [2:0]  base;
    logic [63:0] flat;
    logic [63:0] shifted;
    logic [31:0] flush_target;
    logic        flush_skip;
    logic        reset_skip;

`ifdef FETCH_ALIGNER_RVC_EN
    assign head_rvc     = (buf_q[0][1:0] != 2'b11);
    assign flush_target = bus.flush_pc & ~32'h0000_0001;
    assign flush_skip   = bus.flush_pc[1];
    assign reset_skip   = RESET_PC[1];
`else
    // Without compressed support every fetch is word-granular, so bit 1 of a
    // redirect target carries no meaning and the skip flag never gets set.
    assign head_rvc     = 1'b0;
    assign flush_target = bus.flush_pc & ~32'h0000_0003;
    assign flush_skip   = 1'b0;
    assign reset_skip   = 1'b0;
`endif

    assign bus.fetch_ready  = !rst && !bus.flush && (count_q <= 3'd2);
    assign bus.instr_valid  = !rst && (head_rvc ? (count_q >= 3'd1) : (count_q >= 3'd2));
    assign bus.instr_data   = head_rvc ? {16'h0000, buf_q[0]} : {buf_q[1], buf_q[0]};
    assign bus.instr_is_rvc = head_rvc;
    assign bus.instr_pc     = pc_q;

    assign push = bus.fetch_valid && bus.fetch_ready;
    assign pop  = bus.instr_valid && bus.instr_ready;

    always_comb begin
        pop_cnt = pop ? (head_rvc ? 3'd1 : 3'd2) : 3'd0;
        base    = count_q - pop_cnt;
        flat    = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
        shifted = flat >> {pop_cnt, 4'b0000};
        count_d = base;
        pc_d    = pop ? (pc_q + (head_rvc ? 32'd2 : 32'd4)) : pc_q;
        skip_d  = skip_q;
        for (int i = 0; i < 4; i++) begin
            buf_d[i] = shifted[16*i +: 16];
        end

        // New halfwords land directly behind whatever survives this cycle's pop.
        if (push) begin
            if (skip_q) begin
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) == base) buf_d[i] = bus.fetch_data[31:16];
                end
                count_d = base + 3'd1;
                skip_d  = 1'b0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) == base)        buf_d[i] = bus.fetch_data[15:0];
                    if (3'(i) == base + 3'd1) buf_d[i] = bus.fetch_data[31:16];
                end
                count_d = base + 3'd2;
            end
        end

        if (bus.flush) begin
            count_d = 3'd0;
            pc_d    = flush_target;
            skip_d  = flush_skip;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 3'd0;
            pc_q    <= RESET_PC;
            skip_q  <= reset_skip;
            for (int i = 0; i < 4; i++) buf_q[i] <= 16'h0000;
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
            skip_q  <= skip_d;
            for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed self-checking bench for fetch_aligner; expectations follow the
// FETCH_ALIGNER_RVC_EN setting the RTL is built with.
module tb_fetch_aligner;

`ifdef FETCH_ALIGNER_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] W1     = 32'h00A0_0093;
    localparam logic [31:0] W2     = 32'h00B0_0113;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fetch_aligner_if bus();

    fetch_aligner #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic fv, input logic [31:0] fd,
                                 input logic fl, input logic [31:0] fpc, input logic ir);
        rst             = r;
        bus.fetch_valid = fv;
        bus.fetch_data  = fd;
        bus.flush       = fl;
        bus.flush_pc    = fpc;
        bus.instr_ready = ir;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid, input logic [31:0] exp_data,
                               input logic [31:0] exp_pc, input logic exp_rvc);
        check({tag, ".valid"}, {31'd0, bus.instr_valid}, {31'd0, exp_valid});
        check({tag, ".pc"}, bus.instr_pc, exp_pc);
        if (exp_valid) begin
            check({tag, ".data"}, bus.instr_data, exp_data);
            check({tag, ".rvc"}, {31'd0, bus.instr_is_rvc}, {31'd0, exp_rvc});
        end
    endtask

    task automatic checkReady(input string tag, input logic exp);
        check({tag, ".fetch_ready"}, {31'd0, bus.fetch_ready}, {31'd0, exp});
    endtask

    initial begin
        // Reset held for two edges.
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkReady("rst_hold", 0);
        check("rst_hold.valid", {31'd0, bus.instr_valid}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkReady("after_rst", 1);
        checkOutput("after_rst", 0, 0, RST_PC, 0);

        // A single 32-bit word becomes visible the cycle after it is accepted.
        applyStimulus(0, 1, W1, 0, 0, 0);
        checkReady("w1_offer", 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("w1_out", 1, W1, RST_PC, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("w1_drained", 0, 0, RST_PC + 32'd4, 0);

`ifdef FETCH_ALIGNER_RVC_EN
        // Two compressed instructions in one word.
        applyStimulus(0, 0, 0, 1, 32'h0, 0);
        tick();
        applyStimulus(0, 1, 32'h4501_4501, 0, 0, 0);
        checkOutput("rvc2_empty", 0, 0, 32'h0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("rvc2_first", 1, 32'h0000_4501, 32'h0, 1);
        tick();
        checkOutput("rvc2_second", 1, 32'h0000_4501, 32'h2, 1);
        tick();
        checkOutput("rvc2_done", 0, 0, 32'h4, 0);

        // 32-bit instruction straddling two fetch words.
        applyStimulus(0, 0, 0, 1, 32'h0, 0);
        tick();
        applyStimulus(0, 1, 32'h0093_4505, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("split_rvc", 1, 32'h0000_4505, 32'h0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("split_held", 0, 0, 32'h2, 0);
        applyStimulus(0, 1, 32'h0000_00A0, 0, 0, 0);
        checkOutput("split_held2", 0, 0, 32'h2, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("split_joined", 1, W1, 32'h2, 0);
        tick();
        checkOutput("split_tail", 1, 32'h0, 32'h6, 1);
`endif

        // Backpressure with a full buffer, then an orderly drain.
        applyStimulus(0, 0, 0, 1, 32'h0, 0);
        tick();
        applyStimulus(0, 1, W1, 0, 0, 0);
        tick();
        applyStimulus(0, 1, W2, 0, 0, 0);
        checkReady("fill_count2", 1);
        tick();
        applyStimulus(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkReady("stall", 0);
            checkOutput("stall", 1, W1, 32'h0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drain0", 1, W1, 32'h0, 0);
        tick();
        checkOutput("drain1", 1, W2, 32'h4, 0);
        tick();
        checkOutput("drain_end", 0, 0, 32'h8, 0);

        // Flush discards buffered halfwords and the word offered alongside it.
        applyStimulus(0, 0, 0, 1, 32'h0, 0);
        tick();
        applyStimulus(0, 1, 32'h4501_4501, 0, 0, 0);
        tick();
        applyStimulus(0, 1, W1, 0, 0, 1);
        checkOutput("pre_flush", 1, RVC ? 32'h0000_4501 : 32'h4501_4501, 32'h0, RVC);
        tick();
        applyStimulus(0, 1, 32'hDEAD_BEEF, 1, 32'h0000_0202, 0);
        checkReady("flush_cycle", 0);
        tick();
        applyStimulus(0, 1, 32'h1234_4501, 0, 0, 0);
        checkReady("post_flush", 1);
        checkOutput("post_flush", 0, 0, RVC ? 32'h202 : 32'h200, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("flush_word", 1, RVC ? 32'h0000_1234 : 32'h1234_4501,
                    RVC ? 32'h202 : 32'h200, RVC);
        tick();
        checkOutput("flush_done", 0, 0, 32'h204, 0);

        // Reset mid-stream with entries buffered.
        applyStimulus(0, 1, W1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("pre_rst", 1, W1, 32'h204, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkReady("rst_pulse", 0);
        check("rst_pulse.valid", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkReady("post_rst", 1);
        checkOutput("post_rst", 0, 0, RST_PC, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC of the first halfword fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 fetch_valid  input  1  fetch_data holds a word-aligned 32-bit fetch word.
REQ-005 fetch_ready  output  1  aligner accepts fetch word this cycle.
REQ-006 fetch_data  input  32  fetch word; [15:0] at lower PC, [31:16] at PC+2.
REQ-007 flush  input  1  redirect; discard all buffered halfwords.
REQ-008 flush_pc  input  32  new PC on flush; bit 0 ignored.
REQ-009 instr_valid  output  1  instr_data holds one complete instruction.
REQ-010 instr_ready  input  1  downstream (RVC expander/decode) consumes instruction.
REQ-011 instr_data  output  32  raw instruction; RVC in [15:0], [31:16] zero.
REQ-012 instr_is_rvc  output  1  instr_data is a 16-bit instruction.
REQ-013 instr_pc  output  32  PC of instr_data.

Function
REQ-014 Internal 4-entry halfword FIFO, count 0..4, plus head-PC register and a 1-bit skip flag.
REQ-015 fetch_ready SHALL be 1 iff rst=0, flush=0 and count<=2 (count before any same-cycle pop; no combinational path from instr_ready).
REQ-016 Word push (fetch_valid & fetch_ready): skip=0 pushes [15:0] then [31:16] (+2); skip=1 pushes only [31:16] (+1) and clears skip.
REQ-017 Head halfword bits [1:0]!=2'b11: RVC; instr_valid=1 when count>=1; instr_is_rvc=1.
REQ-018 Head bits [1:0]==2'b11: 32-bit; instr_valid=1 only when count>=2; instr_data={entry1,entry0}.
REQ-019 Pop on instr_valid & instr_ready: 1 entry and instr_pc+=2 (RVC), else 2 entries and instr_pc+=4.
REQ-020 Simultaneous push and pop in one cycle SHALL be supported; next count = count+pushed-popped.
REQ-021 32-bit instruction split across two fetch words SHALL be held (instr_valid=0) until upper halfword arrives; no partial output.
REQ-022 Outputs combinational from FIFO head; instr_data/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-023 flush SHALL have priority over push and pop: next cycle count=0, instr_pc=flush_pc with bit0=0, skip=flush_pc[1]; fetch word presented in flush cycle discarded.
REQ-024 Latency: word accepted in cycle N produces instr_valid in N+1 if it completes an instruction.

Reset
REQ-025 On rst=1 at clk edge: count=0, instr_pc=RESET_PC, skip=RESET_PC[1].
REQ-026 While rst=1: fetch_ready=0, instr_valid=0; instr_data/instr_is_rvc don't-care; rst mid-stream discards all entries.

Configuration
REQ-027 Macro FETCH_ALIGNER_RVC_EN defined: compressed support per REQ-014..REQ-026.
REQ-028 Macro undefined: every instruction treated as 32-bit, instr_is_rvc=0, skip forced 0, flush_pc[1] ignored, pop always 2 entries, PC step 4.

Verification
REQ-029 Reset with RESET_PC=0x100, push 0x00A00093 -> instr_valid next cycle, data 0x00A00093, pc 0x100, is_rvc=0.
REQ-030 Push 0x45014501 at 0x0 -> two RVC outputs 0x4501 at pc 0x0 and 0x2, upper data bits 0.
REQ-031 Push 0x00934505 then 0x000000A0 -> 0x4505 at pc 0x0; 0x00A00093 at pc 0x2 only after second word.
REQ-032 instr_ready=0 for 5 cycles with count=4 -> fetch_ready=0, outputs stable; release -> orderly drain, no loss.
REQ-033 flush with flush_pc=0x202 while 3 entries buffered and fetch_valid=1 -> buffer emptied, next word 0x12344501 yields only 0x1234-halfword path at pc 0x202.
REQ-034 rst pulsed with 2 entries buffered and instr_ready=0 -> instr_valid=0 next cycle, instr_pc=RESET_PC.
